// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequencer for a bit-serial 2's-complement Moore adder.
// It takes two N-bit operands on a start/done handshake and clears the adder.
// It then streams the operands LSB-first into the adder.
// The serial sum is reassembled into an N-bit result with a signed-overflow flag.
module serial_add_ctrl #(
  parameter int N       = 4,
  parameter int SUM_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         ovf,
  output logic         ser_a,
  output logic         ser_b,
  output logic         ser_en,
  output logic         ser_rst,
  input  logic         ser_s
);

  // The counter walks both the SHIFT phase (N cycles) and the DRAIN phase
  // (SUM_LAT cycles), so it is sized for whichever of the two is longer.
  localparam int MAXC = (N > SUM_LAT) ? N : SUM_LAT;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [N-1:0]       a_sh;
  logic [N-1:0]       b_sh;
  logic               a_msb;
  logic               b_msb;
  logic [CW-1:0]      cnt;
  logic [SUM_LAT-1:0] cap_dly;
  logic               cap_v;
  logic [N-1:0]       sum_sh;
  logic [N-1:0]       sum_sh_nxt;
  logic               accept;

  // A request is only looked at between operations; while busy it is ignored.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  // The sum bit on ser_s belongs to the enable that was issued SUM_LAT cycles ago.
  assign cap_v      = cap_dly[SUM_LAT-1];
  assign sum_sh_nxt = cap_v ? {ser_s, sum_sh[N-1:1]} : sum_sh;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so that no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_CLEAR;
      S_CLEAR: state_next = S_SHIFT;
      S_SHIFT: if (cnt == CW'(N - 1)) state_next = S_DRAIN;
      S_DRAIN: if (cnt == CW'(SUM_LAT - 1)) state_next = S_DONE;
      S_DONE:  state_next = start ? S_CLEAR : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs, decoded from the state register and the operand shifters.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    ser_en  = 1'b0;
    ser_rst = 1'b0;
    ser_a   = 1'b0;
    ser_b   = 1'b0;
    unique case (state)
      S_CLEAR: begin
        busy    = 1'b1;
        ser_rst = 1'b1;
      end
      S_SHIFT: begin
        busy   = 1'b1;
        ser_en = 1'b1;
        ser_a  = a_sh[0];
        ser_b  = b_sh[0];
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and shifting, the phase counter, and sum reassembly.
  // The result is published on the edge that enters DONE, so it is valid in the done cycle.
  // NOTE: every datapath register is reset, including the shifters.
  // This keeps sum/ovf at 0 after a reset and leaves no X in the capture pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      cnt     <= '0;
      cap_dly <= '0;
      sum_sh  <= '0;
      sum     <= '0;
      ovf     <= 1'b0;
    end else begin
      cap_dly <= (cap_dly << 1) | SUM_LAT'(ser_en);

      if (accept) begin
        a_sh   <= op_a;
        b_sh   <= op_b;
        a_msb  <= op_a[N-1];
        b_msb  <= op_b[N-1];
        cnt    <= '0;
        sum_sh <= '0;
      end else begin
        sum_sh <= sum_sh_nxt;
        if (state == S_SHIFT) begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= (cnt == CW'(N - 1)) ? '0 : cnt + CW'(1);
        end else if (state == S_DRAIN) begin
          cnt <= cnt + CW'(1);
        end
      end

      if ((state == S_DRAIN) && (state_next == S_DONE)) begin
        sum <= sum_sh_nxt;
        ovf <= (a_msb == b_msb) && (sum_sh_nxt[N-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed bench for serial_add_ctrl (N=4, SUM_LAT=1).
// It is paired with a behavioural Moore serial adder.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       busy;
  logic       done;
  logic [3:0] sum;
  logic       ovf;
  logic       ser_a;
  logic       ser_b;
  logic       ser_en;
  logic       ser_rst;
  logic       ser_s;

  int         vectors    = 0;
  int         miscompares = 0;
  logic [3:0] held_sum   = 4'b0000;
  logic       held_ovf   = 1'b0;

  serial_add_ctrl #(.N(4), .SUM_LAT(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .ovf     (ovf),
    .ser_a   (ser_a),
    .ser_b   (ser_b),
    .ser_en  (ser_en),
    .ser_rst (ser_rst),
    .ser_s   (ser_s)
  );

  always #5 clk = ~clk;

  // Moore serial adder: the registered sum bit appears one cycle after the enable.
  // It is cleared only through ser_rst, so a stale carry would show up if CLEAR were skipped.
  logic add_c;
  logic add_s;
  always @(posedge clk) begin
    if (ser_rst) begin
      add_c <= 1'b0;
      add_s <= 1'b0;
    end else if (ser_en) begin
      add_s <= ser_a ^ ser_b ^ add_c;
      add_c <= (ser_a & ser_b) | (add_c & (ser_a ^ ser_b));
    end
  end
  assign ser_s = add_s;

  // One full operation, cycles 1..7 after the accepting edge.
  // If launched is 0, the task drives start itself. If it is 1, the previous
  // call already queued the start. With noise, extra starts are pulsed while
  // busy. With chain, start is held into DONE with the next operands.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_sum, input logic exp_ovf,
                        input bit launched, input bit noise, input bit chain,
                        input logic [3:0] na, input logic [3:0] nb);
    logic exp_en;
    logic exp_a;
    logic exp_b;
    if (!launched) begin
      @(negedge clk);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
      op_a  = ~a;
      op_b  = ~b;
      if (noise && (c == 2 || c == 4)) begin
        start = 1'b1;
        op_a  = 4'b0111;
        op_b  = 4'b0111;
      end
      exp_en = (c >= 2) && (c <= 5);
      exp_a  = exp_en ? a[c-2] : 1'b0;
      exp_b  = exp_en ? b[c-2] : 1'b0;
      vectors++;
      if (busy !== (c <= 6)) begin
        miscompares++;
        $display("FAIL busy c%0d: got %b want %b", c, busy, (c <= 6));
      end
      vectors++;
      if (done !== (c == 7)) begin
        miscompares++;
        $display("FAIL done c%0d: got %b want %b", c, done, (c == 7));
      end
      vectors++;
      if (ser_rst !== (c == 1)) begin
        miscompares++;
        $display("FAIL ser_rst c%0d: got %b want %b", c, ser_rst, (c == 1));
      end
      vectors++;
      if (ser_en !== exp_en) begin
        miscompares++;
        $display("FAIL ser_en c%0d: got %b want %b", c, ser_en, exp_en);
      end
      vectors++;
      if ({ser_a, ser_b} !== {exp_a, exp_b}) begin
        miscompares++;
        $display("FAIL ser_ab c%0d: got %b%b want %b%b", c, ser_a, ser_b, exp_a, exp_b);
      end
      if (c < 7) begin
        vectors++;
        if ({sum, ovf} !== {held_sum, held_ovf}) begin
          miscompares++;
          $display("FAIL hold c%0d: got sum=%b ovf=%b want sum=%b ovf=%b",
                   c, sum, ovf, held_sum, held_ovf);
        end
      end else begin
        vectors++;
        if (sum !== exp_sum) begin
          miscompares++;
          $display("FAIL sum %b+%b: got %b want %b", a, b, sum, exp_sum);
        end
        vectors++;
        if (ovf !== exp_ovf) begin
          miscompares++;
          $display("FAIL ovf %b+%b: got %b want %b", a, b, ovf, exp_ovf);
        end
        held_sum = exp_sum;
        held_ovf = exp_ovf;
        if (chain) begin
          start = 1'b1;
          op_a  = na;
          op_b  = nb;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op_a  = 4'b0000;
    op_b  = 4'b0000;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, ovf, ser_a, ser_b, ser_en, ser_rst, sum} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b ovf=%b ser=%b%b%b%b sum=%b want all 0",
               busy, done, ovf, ser_a, ser_b, ser_en, ser_rst, sum);
    end
    reset    = 1'b0;
    held_sum = 4'b0000;
    held_ovf = 1'b0;
  endtask

  task automatic test_basic();
    run_op(4'b0011, 4'b0010, 4'b0101, 1'b0, 0, 0, 0, 4'b0, 4'b0);
  endtask

  task automatic test_overflow();
    run_op(4'b0111, 4'b0001, 4'b1000, 1'b1, 0, 0, 0, 4'b0, 4'b0);
    run_op(4'b1101, 4'b1110, 4'b1011, 1'b0, 0, 0, 0, 4'b0, 4'b0);
    run_op(4'b1000, 4'b1000, 4'b0000, 1'b1, 0, 0, 0, 4'b0, 4'b0);
    run_op(4'b1111, 4'b0001, 4'b0000, 1'b0, 0, 0, 0, 4'b0, 4'b0);
  endtask

  task automatic test_back_to_back();
    run_op(4'b0001, 4'b0001, 4'b0010, 1'b0, 0, 1, 1, 4'b0011, 4'b0100);
    run_op(4'b0011, 4'b0100, 4'b0111, 1'b0, 1, 0, 0, 4'b0, 4'b0);
  endtask

  task automatic test_mid_reset();
    // Leave a non-zero result behind so that clearing it on reset is visible.
    run_op(4'b0101, 4'b0100, 4'b1001, 1'b1, 0, 0, 0, 4'b0, 4'b0);
    @(negedge clk);
    start = 1'b1;
    op_a  = 4'b0111;
    op_b  = 4'b0111;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, ser_en, ser_rst, ovf, sum} !== 9'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got busy=%b done=%b ser_en=%b ser_rst=%b ovf=%b sum=%b want all 0",
               busy, done, ser_en, ser_rst, ovf, sum);
    end
    reset    = 1'b0;
    held_sum = 4'b0000;
    held_ovf = 1'b0;
    run_op(4'b0110, 4'b0001, 4'b0111, 1'b0, 0, 0, 0, 4'b0, 4'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
